red_track_ctrl: RTL and testbench

- Frame-level sequencer for the red-object tracking datapath in the motor proof-of-concept.
- After the capture side signals a complete 80x60 RGB444 frame, it takes ownership of the frame-buffer read port and scans every pixel.
- It builds a per-column red histogram, searches for the column with the most red pixels, and presents the result to the motor/LED logic through a valid/ack handshake.

---
 rtl/red_track_if.sv | 33 +++
 rtl/red_track_ctrl.sv | 180 ++++++++++++++++++
 tb/tb_red_track_ctrl.sv | 242 ++++++++++++++++++++++++
 3 files changed

// File: rtl/red_track_if.sv
// Frame-buffer read port and result handshake between the
// red-object tracker and its capture/motor neighbours.
interface red_track_if #(
  parameter int C_NB_ADDR = 13,
  parameter int C_NB_PXL  = 12,
  parameter int C_NB_HIST = 6
);
  logic                 frame_rdy;
  logic                 hold_buf;
  logic [C_NB_ADDR-1:0] rd_addr;
  logic [C_NB_PXL-1:0]  rd_pxl;
  logic                 res_valid;
  logic                 res_ack;
  logic [6:0]           res_col;
  logic [C_NB_HIST-1:0] res_cnt;
  logic                 res_found;
  logic                 frame_ovr;
  logic [7:0]           leds;

  modport master (
    input  frame_rdy, rd_pxl, res_ack,
    output hold_buf, rd_addr, res_valid,
    output res_col, res_cnt, res_found,
    output frame_ovr, leds
  );

  modport slave (
    output frame_rdy, rd_pxl, res_ack,
    input  hold_buf, rd_addr, res_valid,
    input  res_col, res_cnt, res_found,
    input  frame_ovr, leds
  );
endinterface

// File: rtl/red_track_ctrl.sv
// Frame sequencer: scans a captured frame, builds a per-column
// red histogram and reports the column with the most red pixels.
module red_track_ctrl #(
  parameter int C_COLS    = 80,
  parameter int C_ROWS    = 60,
  parameter int C_NB_ADDR = 13,
  parameter int C_NB_HIST = 6,
  parameter int C_MIN_CNT = 4
) (
  input logic        clk,
  input logic        rst,
  red_track_if.master bus
);

  localparam logic [C_NB_ADDR-1:0] LAST_ADDR =
    C_NB_ADDR'(C_COLS * C_ROWS - 1);
  localparam logic [6:0] LAST_COL = 7'(C_COLS - 1);
  localparam logic [C_NB_HIST-1:0] HMAX = '1;
  localparam logic [C_NB_HIST-1:0] MIN_CNT =
    C_NB_HIST'(C_MIN_CNT);

  typedef enum logic [2:0] {
    S_IDLE,
    S_CLEAR,
    S_SCAN,
    S_DRAIN,
    S_SEARCH,
    S_RESULT
  } state_t;

  state_t               state_q, state_d;
  logic [C_NB_ADDR-1:0] rd_addr_q, rd_addr_d;
  logic [6:0]           col_q, col_d;
  logic [6:0]           col_d1_q, col_d1_d;
  logic                 iss_q, iss_d;
  logic [6:0]           k_q, k_d;
  logic [C_NB_HIST-1:0] best_cnt_q, best_cnt_d;
  logic [6:0]           best_col_q, best_col_d;
  logic                 hold_buf_q, hold_buf_d;
  logic                 res_valid_q, res_valid_d;
  logic [6:0]           res_col_q, res_col_d;
  logic [C_NB_HIST-1:0] res_cnt_q, res_cnt_d;
  logic                 res_found_q, res_found_d;
  logic                 frame_ovr_q, frame_ovr_d;
  logic [7:0]           leds_q, leds_d;
  logic [C_NB_HIST-1:0] bin_q [C_COLS];
  logic [C_NB_HIST-1:0] bin_d [C_COLS];
  logic                 is_red;

  assign is_red = bus.rd_pxl[11] & ~bus.rd_pxl[7]
                & ~bus.rd_pxl[3];

  always_comb begin
    state_d     = state_q;
    rd_addr_d   = rd_addr_q;
    col_d       = col_q;
    col_d1_d    = col_q;
    iss_d       = (state_q == S_SCAN);
    k_d         = k_q;
    best_cnt_d  = best_cnt_q;
    best_col_d  = best_col_q;
    hold_buf_d  = hold_buf_q;
    res_valid_d = res_valid_q;
    res_col_d   = res_col_q;
    res_cnt_d   = res_cnt_q;
    res_found_d = res_found_q;
    leds_d      = leds_q;
    frame_ovr_d = bus.frame_rdy && (state_q != S_IDLE);
    bin_d       = bin_q;

    // iss_q marks a cycle whose rd_pxl belongs to col_d1_q
    if (iss_q && is_red && bin_q[col_d1_q] != HMAX)
      bin_d[col_d1_q] = bin_q[col_d1_q] + 1'b1;

    unique case (state_q)
      S_IDLE: begin
        if (bus.frame_rdy) begin
          state_d    = S_CLEAR;
          hold_buf_d = 1'b1;
          rd_addr_d  = '0;
          col_d      = '0;
        end
      end
      S_CLEAR: begin
        for (int i = 0; i < C_COLS; i++)
          bin_d[i] = '0;
        state_d = S_SCAN;
      end
      S_SCAN: begin
        if (rd_addr_q == LAST_ADDR)
          state_d = S_DRAIN;
        else
          rd_addr_d = rd_addr_q + 1'b1;
        col_d = (col_q == LAST_COL) ? '0 : col_q + 1'b1;
      end
      S_DRAIN: begin
        state_d    = S_SEARCH;
        hold_buf_d = 1'b0;
        k_d        = '0;
        best_cnt_d = '0;
        best_col_d = '0;
      end
      S_SEARCH: begin
        if (bin_q[k_q] > best_cnt_q) begin
          best_cnt_d = bin_q[k_q];
          best_col_d = k_q;
        end
        if (k_q == LAST_COL) begin
          state_d     = S_RESULT;
          res_col_d   = best_col_d;
          res_cnt_d   = best_cnt_d;
          res_found_d = (best_cnt_d >= MIN_CNT);
          res_valid_d = 1'b1;
          leds_d      = res_found_d
                      ? (8'h80 >> (best_col_d / 7'd10))
                      : 8'h00;
        end else begin
          k_d = k_q + 1'b1;
        end
      end
      S_RESULT: begin
        if (bus.res_ack) begin
          res_valid_d = 1'b0;
          state_d     = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      rd_addr_q   <= '0;
      col_q       <= '0;
      col_d1_q    <= '0;
      iss_q       <= 1'b0;
      k_q         <= '0;
      best_cnt_q  <= '0;
      best_col_q  <= '0;
      hold_buf_q  <= 1'b0;
      res_valid_q <= 1'b0;
      res_col_q   <= '0;
      res_cnt_q   <= '0;
      res_found_q <= 1'b0;
      frame_ovr_q <= 1'b0;
      leds_q      <= '0;
      for (int i = 0; i < C_COLS; i++)
        bin_q[i] <= '0;
    end else begin
      state_q     <= state_d;
      rd_addr_q   <= rd_addr_d;
      col_q       <= col_d;
      col_d1_q    <= col_d1_d;
      iss_q       <= iss_d;
      k_q         <= k_d;
      best_cnt_q  <= best_cnt_d;
      best_col_q  <= best_col_d;
      hold_buf_q  <= hold_buf_d;
      res_valid_q <= res_valid_d;
      res_col_q   <= res_col_d;
      res_cnt_q   <= res_cnt_d;
      res_found_q <= res_found_d;
      frame_ovr_q <= frame_ovr_d;
      leds_q      <= leds_d;
      for (int i = 0; i < C_COLS; i++)
        bin_q[i] <= bin_d[i];
    end
  end

  assign bus.hold_buf  = hold_buf_q;
  assign bus.rd_addr   = rd_addr_q;
  assign bus.res_valid = res_valid_q;
  assign bus.res_col   = res_col_q;
  assign bus.res_cnt   = res_cnt_q;
  assign bus.res_found = res_found_q;
  assign bus.frame_ovr = frame_ovr_q;
  assign bus.leds      = leds_q;

endmodule

// File: tb/tb_red_track_ctrl.sv
// Bench for red_track_ctrl: frame-buffer model plus a histogram
// reference computed directly from the red-pixel rule.
module tb_red_track_ctrl;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  red_track_if bus ();

  red_track_ctrl dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  logic [11:0] fb [0:4799];

  always @(posedge clk)
    bus.rd_pxl <= fb[bus.rd_addr];

  int total = 0;
  int bad   = 0;
  int exp_col;
  int exp_cnt;
  int exp_found;
  logic [7:0] exp_leds;

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [11:0] red_px();
    logic [11:0] p;
    p = 12'($urandom);
    p[11] = 1'b1;
    p[7]  = 1'b0;
    p[3]  = 1'b0;
    return p;
  endfunction

  task automatic fill_black();
    for (int i = 0; i < 4800; i++) fb[i] = 12'h000;
  endtask

  task automatic fill_rand();
    for (int i = 0; i < 4800; i++) fb[i] = 12'($urandom);
  endtask

  task automatic paint(input int col, input int nrows);
    for (int r = 0; r < nrows; r++) fb[r * 80 + col] = red_px();
  endtask

  task automatic model();
    int h [80];
    int best;
    int bcol;
    logic [11:0] p;
    for (int c = 0; c < 80; c++) h[c] = 0;
    for (int a = 0; a < 4800; a++) begin
      p = fb[a];
      if (p[11] && !p[7] && !p[3] && h[a % 80] < 63)
        h[a % 80]++;
    end
    best = 0;
    bcol = 0;
    for (int c = 0; c < 80; c++)
      if (h[c] > best) begin
        best = h[c];
        bcol = c;
      end
    exp_col   = bcol;
    exp_cnt   = best;
    exp_found = (best >= 4) ? 1 : 0;
    exp_leds  = exp_found ? 8'(1 << (7 - bcol / 10)) : 8'h00;
  endtask

  task automatic run_frame(input int ovr_at, input string tag);
    int n;
    logic got;
    model();
    @(negedge clk) bus.frame_rdy = 1'b1;
    @(posedge clk);
    #1 bus.frame_rdy = 1'b0;
    chk({tag, "_hold_on"}, bus.hold_buf, 1);
    n = 0;
    got = 1'b0;
    while (!got && n < 6000) begin
      @(posedge clk);
      n++;
      #1;
      if (ovr_at > 0) begin
        if (n == ovr_at) bus.frame_rdy = 1'b1;
        else if (n == ovr_at + 1) begin
          bus.frame_rdy = 1'b0;
          chk({tag, "_ovr_hi"}, bus.frame_ovr, 1);
        end else if (n == ovr_at + 2)
          chk({tag, "_ovr_lo"}, bus.frame_ovr, 0);
      end
      got = bus.res_valid;
    end
    chk({tag, "_latency"}, n, 4882);
    chk({tag, "_col"}, bus.res_col, exp_col);
    chk({tag, "_cnt"}, bus.res_cnt, exp_cnt);
    chk({tag, "_found"}, bus.res_found, exp_found);
    chk({tag, "_leds"}, bus.leds, exp_leds);
    chk({tag, "_hold_off"}, bus.hold_buf, 0);
  endtask

  task automatic release_res(input string tag);
    bus.res_ack = 1'b1;
    @(posedge clk);
    #1 bus.res_ack = 1'b0;
    chk({tag, "_ack_valid"}, bus.res_valid, 0);
    chk({tag, "_ack_col"}, bus.res_col, exp_col);
    chk({tag, "_ack_leds"}, bus.leds, exp_leds);
  endtask

  initial begin
    int n;
    logic ok;
    rst = 1'b1;
    bus.frame_rdy = 1'b0;
    bus.res_ack = 1'b0;
    fill_black();
    repeat (3) @(posedge clk);
    #1;
    chk("rst_addr", bus.rd_addr, 0);
    chk("rst_hold", bus.hold_buf, 0);
    chk("rst_valid", bus.res_valid, 0);
    chk("rst_leds", bus.leds, 0);
    chk("rst_ovr", bus.frame_ovr, 0);
    @(negedge clk) rst = 1'b0;

    bus.res_ack = 1'b1;
    repeat (5) @(posedge clk);
    #1 bus.res_ack = 1'b0;
    chk("idle_ack_valid", bus.res_valid, 0);
    chk("idle_ack_hold", bus.hold_buf, 0);

    fill_black();
    paint(25, 60);
    run_frame(0, "c25");
    release_res("c25");

    fill_black();
    run_frame(0, "black");
    release_res("black");

    fill_black();
    paint(10, 30);
    paint(50, 30);
    run_frame(0, "tie");
    release_res("tie");

    fill_black();
    paint(10, 30);
    paint(50, 31);
    run_frame(0, "c50");
    release_res("c50");

    fill_black();
    paint(79, 3);
    run_frame(0, "c79");
    release_res("c79");

    fill_rand();
    run_frame(500, "ovr");
    ok = 1'b1;
    for (int i = 0; i < 200; i++) begin
      @(posedge clk);
      #1;
      if (i == 50) bus.frame_rdy = 1'b1;
      if (i == 51) begin
        bus.frame_rdy = 1'b0;
        chk("res_ovr_hi", bus.frame_ovr, 1);
      end
      if (i == 52) chk("res_ovr_lo", bus.frame_ovr, 0);
      if (!(bus.res_valid === 1'b1 &&
            bus.res_col === 7'(exp_col) &&
            bus.res_cnt === 6'(exp_cnt) &&
            bus.res_found === 1'(exp_found) &&
            bus.leds === exp_leds))
        ok = 1'b0;
    end
    chk("hold200_stable", ok, 1);
    release_res("ovr");

    fill_rand();
    run_frame(0, "rnd1");
    release_res("rnd1");

    fill_rand();
    paint(33, 60);
    model();
    @(negedge clk) bus.frame_rdy = 1'b1;
    @(posedge clk);
    #1 bus.frame_rdy = 1'b0;
    n = 0;
    while (bus.rd_addr !== 13'd2000 && n < 3000) begin
      @(posedge clk);
      n++;
      #1;
    end
    chk("abort_reach2000", bus.rd_addr, 2000);
    rst = 1'b1;
    @(posedge clk);
    #1;
    chk("abort_addr", bus.rd_addr, 0);
    chk("abort_hold", bus.hold_buf, 0);
    chk("abort_leds", bus.leds, 0);
    chk("abort_valid", bus.res_valid, 0);
    @(negedge clk) rst = 1'b0;
    ok = 1'b1;
    repeat (5) begin
      @(posedge clk);
      #1;
      if (bus.hold_buf !== 1'b0 || bus.res_valid !== 1'b0)
        ok = 1'b0;
    end
    chk("abort_idle", ok, 1);

    fill_black();
    paint(5, 12);
    run_frame(0, "post_rst");
    release_res("post_rst");

    fill_rand();
    run_frame(0, "rnd2");
    release_res("rnd2");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
